// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types, constants and helpers for the iterative RV32M
// multiply/divide unit.
//   mdu_op_e    - funct3 encodings of the M-extension ops
//   mdu_state_e - controller states
//   DIV_ZERO_Q  - quotient returned for a divide by zero (all ones)
//   INT_MIN     - most negative XLEN-bit value (signed-overflow dividend)
//   is_signed_a / is_signed_b - operand signedness per op
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    localparam logic [MDU_XLEN-1:0] DIV_ZERO_Q = {MDU_XLEN{1'b1}};
    localparam logic [MDU_XLEN-1:0] INT_MIN    = {1'b1, {(MDU_XLEN-1){1'b0}}};

    // rs1 is treated as signed for MULH, MULHSU, DIV and REM
    function automatic logic is_signed_a(input mdu_op_e op);
        case (op)
            OP_MULH, OP_MULHSU, OP_DIV, OP_REM: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // rs2 is treated as signed for MULH, DIV and REM
    function automatic logic is_signed_b(input mdu_op_e op);
        case (op)
            OP_MULH, OP_DIV, OP_REM: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// mdu_sequencer_if: handshake bundle between execute/writeback and the MDU.
//   master modport - execute stage side (drives op request, flush, out_ready)
//   slave modport  - MDU side (drives in_ready, out_valid, result, busy)
interface mdu_sequencer_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, funct3, op_a, op_b, flush, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, funct3, op_a, op_b, flush, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/mdu_step.sv
// mdu_step: one combinational iteration of the shared datapath.
//   is_div  - 1: restoring shift-subtract step, 0: shift-add step
//   acc_in  - {hi, lo}; mul: hi=partial product, lo=remaining multiplier;
//             div: hi=partial remainder, lo=dividend bits / quotient bits
//   operand - multiplicand (mul) or divisor (div), both magnitudes
//   acc_out - accumulator after the step
module mdu_step #(
    parameter int XLEN = 32
) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);
    logic [XLEN-1:0] hi_s;
    logic [XLEN-1:0] lo_s;
    logic [XLEN:0]   sum_s;
    logic [XLEN:0]   shifted_s;
    logic [XLEN:0]   trial_s;

    assign hi_s = acc_in[2*XLEN-1:XLEN];
    assign lo_s = acc_in[XLEN-1:0];

    // Single shift-add / shift-subtract step
    always_comb begin
        sum_s     = {1'b0, hi_s} + {1'b0, operand};
        shifted_s = {hi_s, lo_s[XLEN-1]};
        // Partial remainder stays below the divisor, so bit XLEN of the
        // trial difference is a clean borrow flag.
        trial_s   = shifted_s - {1'b0, operand};
        acc_out   = acc_in;
        if (is_div) begin
            if (!trial_s[XLEN]) begin
                acc_out = {trial_s[XLEN-1:0], lo_s[XLEN-2:0], 1'b1};
            end else begin
                acc_out = {shifted_s[XLEN-1:0], lo_s[XLEN-2:0], 1'b0};
            end
        end else begin
            // Carry out of the add is shifted into the top of the product
            if (lo_s[0]) begin
                acc_out = {sum_s, lo_s[XLEN-1:1]};
            end else begin
                acc_out = {1'b0, hi_s, lo_s[XLEN-1:1]};
            end
        end
    end
endmodule

// File: rtl/mdu_sequencer.sv
// mdu_sequencer: iterative RV32M multiply/divide unit.
//   clk   - core clock
//   reset - synchronous active-high reset
//   bus   - slave side of mdu_sequencer_if (op request in, result out)
// Operands are latched as magnitudes on accept, XLEN shift-add or restoring
// shift-subtract steps run in CALC, and FIX applies signs and picks the word.
// Divide-by-zero and signed overflow bypass CALC and go straight to DONE.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    mdu_sequencer_if.slave  bus
);
    localparam int CW = $clog2(XLEN);

    mdu_state_e        state_r, state_nx_s;
    mdu_op_e           op_r, op_in_s;
    logic [CW-1:0]     cnt_r;
    logic [2*XLEN-1:0] acc_r, acc_step_s, prod_s;
    logic [XLEN-1:0]   opnd_r, result_r, fix_res_s, fast_res_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s, quo_s, rem_s;
    logic              sign_a_r, sign_b_r, sign_a_in_s, sign_b_in_s;
    logic              is_div_r, is_div_in_s;
    logic              in_ready_r, out_valid_r, busy_r;
    logic              accept_s, fast_s;

    assign op_in_s     = mdu_op_e'(bus.funct3);
    assign is_div_in_s = bus.funct3[2];
    assign sign_a_in_s = is_signed_a(op_in_s) & bus.op_a[XLEN-1];
    assign sign_b_in_s = is_signed_b(op_in_s) & bus.op_b[XLEN-1];
    assign mag_a_s     = sign_a_in_s ? -bus.op_a : bus.op_a;
    assign mag_b_s     = sign_b_in_s ? -bus.op_b : bus.op_b;
    // A flush in the same cycle kills the request
    assign accept_s    = bus.in_valid & (state_r == IDLE) & ~bus.flush;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.result    = result_r;
    assign bus.busy      = busy_r;

    mdu_step #(.XLEN(XLEN)) u_step (
        .is_div  (is_div_r),
        .acc_in  (acc_r),
        .operand (opnd_r),
        .acc_out (acc_step_s)
    );

    // Divide corner cases resolved directly at accept time
    always_comb begin
        fast_s     = 1'b0;
        fast_res_s = {XLEN{1'b0}};
        if (is_div_in_s && (bus.op_b == {XLEN{1'b0}})) begin
            fast_s = 1'b1;
            if (bus.funct3[1]) begin
                fast_res_s = bus.op_a;
            end else begin
                fast_res_s = DIV_ZERO_Q;
            end
        end else if ((op_in_s == OP_DIV || op_in_s == OP_REM) &&
                     (bus.op_a == INT_MIN) && (bus.op_b == {XLEN{1'b1}})) begin
            fast_s = 1'b1;
            if (op_in_s == OP_DIV) begin
                fast_res_s = INT_MIN;
            end else begin
                fast_res_s = {XLEN{1'b0}};
            end
        end else begin
            fast_s     = 1'b0;
            fast_res_s = {XLEN{1'b0}};
        end
    end

    // Sign correction and word selection for the FIX cycle
    always_comb begin
        prod_s = (sign_a_r ^ sign_b_r) ? -acc_r : acc_r;
        quo_s  = (sign_a_r ^ sign_b_r) ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
        rem_s  = sign_a_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
        case (op_r)
            OP_MUL:                       fix_res_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res_s = quo_s;
            OP_REM, OP_REMU:              fix_res_s = rem_s;
            default:                      fix_res_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_nx_s = state_r;
        if (bus.flush) begin
            state_nx_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_nx_s = fast_s ? DONE : CALC;
                    end else begin
                        state_nx_s = IDLE;
                    end
                end
                CALC: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_nx_s = FIX;
                    end else begin
                        state_nx_s = CALC;
                    end
                end
                FIX:  state_nx_s = DONE;
                DONE: begin
                    if (bus.out_ready) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = DONE;
                    end
                end
                default: state_nx_s = IDLE;
            endcase
        end
    end

    // State, datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            op_r        <= OP_MUL;
            cnt_r       <= {CW{1'b0}};
            acc_r       <= {(2*XLEN){1'b0}};
            opnd_r      <= {XLEN{1'b0}};
            result_r    <= {XLEN{1'b0}};
            sign_a_r    <= 1'b0;
            sign_b_r    <= 1'b0;
            is_div_r    <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            in_ready_r  <= (state_nx_s == IDLE);
            out_valid_r <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        op_r     <= op_in_s;
                        sign_a_r <= sign_a_in_s;
                        sign_b_r <= sign_b_in_s;
                        is_div_r <= is_div_in_s;
                        acc_r    <= {{XLEN{1'b0}}, mag_a_s};
                        opnd_r   <= mag_b_s;
                        cnt_r    <= CW'(XLEN - 1);
                        if (fast_s) begin
                            result_r <= fast_res_s;
                        end
                    end
                end
                CALC: begin
                    acc_r <= acc_step_s;
                    if (cnt_r != {CW{1'b0}}) begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                FIX:     result_r <= fix_res_s;
                default: ;
            endcase
        end
    end
endmodule
